// File: rtl/shift_pkg.sv
// Shared types and widths for the shift issue stage.
// The S0 payload struct is used by the stage and mirrored by the shifter ports.
package shift_pkg;

    localparam int DATA_W = 64;
    localparam int AMT_W  = 6;

    typedef enum logic [1:0] {
        SHIFT_LL = 2'b00,
        SHIFT_RL = 2'b01,
        SHIFT_LA = 2'b10,
        SHIFT_RA = 2'b11
    } shift_type_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
        shift_type_e       op;
    } s0_t;

endpackage

// File: rtl/shift_pipe_stage_if.sv
// Request/result handshake bundle for the shift issue stage.
// master drives requests and accepts results; slave is the stage itself.
interface shift_pipe_stage_if #(
    parameter int TAG_W = 4
);
    import shift_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [AMT_W-1:0]  in_amount;
    logic [1:0]        in_type;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;
    logic              out_zero;
    logic              busy;

    modport master (
        output in_valid, in_data, in_amount, in_type, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, out_zero, busy
    );

    modport slave (
        input  in_valid, in_data, in_amount, in_type, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, out_zero, busy
    );

endinterface

// File: rtl/barrel_shifter64.sv
// Combinational 64-bit barrel shifter, one log stage per amount bit.
// Left arithmetic behaves as logical left; right arithmetic fills with bit 63.
module barrel_shifter64
    import shift_pkg::*;
(
    input  logic [DATA_W-1:0] i_data,
    input  logic [AMT_W-1:0]  i_amount,
    input  shift_type_e       i_type,
    output logic [DATA_W-1:0] o_result
);

    logic              w_left;
    logic              w_fill;
    logic [DATA_W-1:0] w_acc;

    assign w_left = (i_type == SHIFT_LL) || (i_type == SHIFT_LA);
    assign w_fill = (i_type == SHIFT_RA) && i_data[DATA_W-1];

    always_comb begin
        w_acc = i_data;
        for (int i = 0; i < AMT_W; i++) begin
            if (i_amount[i]) begin
                if (w_left) begin
                    w_acc = w_acc << (1 << i);
                end else begin
                    w_acc = (w_acc >> (1 << i))
                          | (w_fill ? ~({DATA_W{1'b1}} >> (1 << i))
                                    : {DATA_W{1'b0}});
                end
            end
        end
    end

    assign o_result = w_acc;

endmodule

// File: rtl/shift_pipe_stage.sv
// Two-slot registered issue stage around the barrel shifter.
// S0 holds operands, S1 holds the result; ready ripples back combinationally.
module shift_pipe_stage
    import shift_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    shift_pipe_stage_if.slave   bus
);

    logic              w_s1_en;
    logic              w_in_ready;
    logic [DATA_W-1:0] w_shift;
    logic              w_zero;

    logic              r_v0;
    s0_t               r_s0;
    logic [TAG_W-1:0]  r_tag0;

    logic              r_v1;
    logic [DATA_W-1:0] r_res;
    logic [TAG_W-1:0]  r_tag1;
    logic              r_zero;

    assign w_s1_en    = !r_v1 || bus.out_ready;
    assign w_in_ready = !r_v0 || w_s1_en;

    barrel_shifter64 u_shifter (
        .i_data   (r_s0.data),
        .i_amount (r_s0.amt),
        .i_type   (r_s0.op),
        .o_result (w_shift)
    );

    assign w_zero = (w_shift == {DATA_W{1'b0}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0   <= 1'b0;
            r_s0   <= '0;
            r_tag0 <= '0;
        end else if (w_in_ready) begin
            r_v0 <= bus.in_valid;
            if (bus.in_valid) begin
                r_s0.data <= bus.in_data;
                r_s0.amt  <= bus.in_amount;
                r_s0.op   <= shift_type_e'(bus.in_type);
                r_tag0    <= bus.in_tag;
            end
        end
    end

    // Result slot only reloads when it is empty or being drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_res  <= '0;
            r_tag1 <= '0;
            r_zero <= 1'b0;
        end else if (w_s1_en) begin
            r_v1 <= r_v0;
            if (r_v0) begin
                r_res  <= w_shift;
                r_tag1 <= r_tag0;
                r_zero <= w_zero;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_v1;
    assign bus.out_result = r_res;
    assign bus.out_tag    = r_tag1;
    assign bus.out_zero   = r_zero;
    assign bus.busy       = r_v0 || r_v1;

endmodule

// File: tb/tb_shift_pipe_stage.sv
// Self-checking bench for shift_pipe_stage.
// Reference: arithmetic shift model plus a FIFO of in-flight expectations.
module tb_shift_pipe_stage;

    localparam int TW = 4;

    typedef struct {
        logic [63:0]   d;
        logic [5:0]    a;
        logic [1:0]    t;
        logic [TW-1:0] tag;
    } stim_t;

    typedef struct {
        logic [63:0]   res;
        logic [TW-1:0] tag;
        logic          z;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shift_pipe_stage_if #(.TAG_W(TW)) bus();

    shift_pipe_stage #(.TAG_W(TW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    stim_t         stim[$];
    exp_t          mdl[$];
    logic [63:0]   got_res[$];
    logic [TW-1:0] got_tag[$];
    logic          got_z[$];

    // Shifts expressed as multiply/divide by 2**amt; sign fill as a top-bit mask.
    function automatic logic [63:0] ref_shift(logic [63:0] d, logic [5:0] a,
                                              logic [1:0] t);
        logic [63:0] p;
        logic [63:0] r;
        p = 64'd1 << a;
        if (t[0] == 1'b0) begin
            r = d * p;
        end else begin
            r = d / p;
            if (t[1] && d[63]) r = r | ~(64'hFFFF_FFFF_FFFF_FFFF / p);
        end
        return r;
    endfunction

    function automatic stim_t mk(logic [63:0] d, logic [5:0] a, logic [1:0] t,
                                 logic [TW-1:0] tag);
        stim_t s;
        s.d = d; s.a = a; s.t = t; s.tag = tag;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.in_valid  = 1'b1;
        bus.in_data   = s.d;
        bus.in_amount = s.a;
        bus.in_type   = s.t;
        bus.in_tag    = s.tag;
    endtask

    task automatic clear_got();
        got_res.delete();
        got_tag.delete();
        got_z.delete();
    endtask

    // Scenario engine: feeds stim with probability pin, drains with pout,
    // checks every cycle against the FIFO model. Called at posedge+1.
    task automatic run(input int pin, input int pout, input int max_cyc,
                       output int used);
        logic          pv;
        logic          pr;
        logic [63:0]   pres;
        logic [TW-1:0] ptag;
        logic          pz;
        logic          eir;
        logic          eov;
        exp_t          e;
        pv = 1'b0; pr = 1'b0; pres = '0; ptag = '0; pz = 1'b0;
        used = 0;
        while ((stim.size() > 0 || mdl.size() > 0) && used < max_cyc) begin
            if (stim.size() > 0 && $urandom_range(99) < pin) drive(stim[0]);
            else bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(99) < pout);
            @(negedge clk);
            eir = !(mdl.size() == 2 && !bus.out_ready);
            eov = mdl.size() > 0 && cyc >= mdl[0].acc + 2;
            checks += 3;
            if (bus.in_ready !== eir) begin
                failures++;
                $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, eir);
            end
            if (bus.out_valid !== eov) begin
                failures++;
                $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, eov);
            end
            if (bus.busy !== (mdl.size() > 0)) begin
                failures++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, mdl.size() > 0);
            end
            if (eov) begin
                checks++;
                if (bus.out_result !== mdl[0].res || bus.out_tag !== mdl[0].tag ||
                    bus.out_zero !== mdl[0].z) begin
                    failures++;
                    $display("FAIL result cyc=%0d got=%h/%h/%b exp=%h/%h/%b", cyc,
                             bus.out_result, bus.out_tag, bus.out_zero,
                             mdl[0].res, mdl[0].tag, mdl[0].z);
                end
            end
            if (pv && !pr) begin
                checks++;
                if (bus.out_result !== pres || bus.out_tag !== ptag || bus.out_zero !== pz) begin
                    failures++;
                    $display("FAIL stall_stable cyc=%0d got=%h exp=%h", cyc,
                             bus.out_result, pres);
                end
            end
            pv = bus.out_valid; pr = bus.out_ready;
            pres = bus.out_result; ptag = bus.out_tag; pz = bus.out_zero;
            if (eov && bus.out_ready) begin
                got_res.push_back(bus.out_result);
                got_tag.push_back(bus.out_tag);
                got_z.push_back(bus.out_zero);
                void'(mdl.pop_front());
            end
            if (bus.in_valid && eir) begin
                e.res = ref_shift(stim[0].d, stim[0].a, stim[0].t);
                e.tag = stim[0].tag;
                e.z   = (e.res == 64'd0);
                e.acc = cyc;
                mdl.push_back(e);
                void'(stim.pop_front());
            end
            @(posedge clk); #1;
            cyc++;
            used++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (stim.size() != 0 || mdl.size() != 0) begin
            failures++;
            $display("FAIL run_timeout pending_in=%0d pending_out=%0d", stim.size(), mdl.size());
            stim.delete();
            mdl.delete();
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_amount = '0;
        bus.in_type = '0; bus.in_tag = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.busy, bus.out_zero} !== 4'b0100 ||
            bus.out_result !== 64'd0 || bus.out_tag !== '0) begin
            failures++;
            $display("FAIL por_state got ov=%b ir=%b busy=%b z=%b res=%h tag=%h exp 0/1/0/0/0/0",
                     bus.out_valid, bus.in_ready, bus.busy, bus.out_zero,
                     bus.out_result, bus.out_tag);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        drive(mk(64'h1234, 6'd1, 2'b00, 4'd5));
        @(posedge clk); #1;
        bus.in_tag = 4'd6;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if ({bus.busy, bus.out_valid, bus.in_ready} !== 3'b110) begin
            failures++;
            $display("FAIL full_before_reset got busy/ov/ir=%b%b%b exp=110",
                     bus.busy, bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.busy} !== 3'b010 ||
            bus.out_result !== 64'd0 || bus.out_tag !== '0) begin
            failures++;
            $display("FAIL mid_reset got ov/ir/busy=%b%b%b res=%h exp=010 res=0",
                     bus.out_valid, bus.in_ready, bus.busy, bus.out_result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                failures++;
                $display("FAIL stale_after_reset got ov=%b busy=%b exp=0/0",
                         bus.out_valid, bus.busy);
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_types();
        logic [63:0] exp_r [4];
        int used;
        exp_r[0] = 64'h0000_0000_0000_0F10;
        exp_r[1] = 64'h0800_0000_0000_000F;
        exp_r[2] = 64'h0000_0000_0000_0F10;
        exp_r[3] = 64'hF800_0000_0000_000F;
        clear_got();
        for (int i = 0; i < 4; i++)
            stim.push_back(mk(64'h8000_0000_0000_00F1, 6'd4, 2'(i), 4'(i + 1)));
        run(100, 100, 50, used);
        checks++;
        if (got_res.size() != 4) begin
            failures++;
            $display("FAIL types_count got=%0d exp=4", got_res.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_res[i] !== exp_r[i] || got_tag[i] !== 4'(i + 1)) begin
                    failures++;
                    $display("FAIL type_%0d got=%h/%h exp=%h/%h", i, got_res[i],
                             got_tag[i], exp_r[i], 4'(i + 1));
                end
            end
        end
    endtask

    task automatic test_edges();
        logic [63:0] d;
        logic [63:0] exp_r [8];
        logic        exp_z [8];
        int used;
        d = {$urandom, $urandom} | 64'h1;
        clear_got();
        for (int i = 0; i < 4; i++) begin
            stim.push_back(mk(d, 6'd0, 2'(i), 4'(i)));
            exp_r[i] = d;
            exp_z[i] = 1'b0;
        end
        stim.push_back(mk(64'h8000_0000_0000_0000, 6'd63, 2'b11, 4'd4));
        stim.push_back(mk(64'h8000_0000_0000_0000, 6'd63, 2'b01, 4'd5));
        stim.push_back(mk(64'd1, 6'd63, 2'b00, 4'd6));
        stim.push_back(mk(64'd1, 6'd1, 2'b01, 4'd7));
        exp_r[4] = 64'hFFFF_FFFF_FFFF_FFFF; exp_z[4] = 1'b0;
        exp_r[5] = 64'h1;                   exp_z[5] = 1'b0;
        exp_r[6] = 64'h8000_0000_0000_0000; exp_z[6] = 1'b0;
        exp_r[7] = 64'h0;                   exp_z[7] = 1'b1;
        run(100, 100, 50, used);
        checks++;
        if (got_res.size() != 8) begin
            failures++;
            $display("FAIL edges_count got=%0d exp=8", got_res.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (got_res[i] !== exp_r[i] || got_z[i] !== exp_z[i]) begin
                    failures++;
                    $display("FAIL edge_%0d got=%h z=%b exp=%h z=%b", i, got_res[i],
                             got_z[i], exp_r[i], exp_z[i]);
                end
            end
        end
    endtask

    task automatic test_stream();
        int used;
        clear_got();
        for (int i = 0; i < 100; i++)
            stim.push_back(mk({$urandom, $urandom}, 6'($urandom_range(63)),
                              2'($urandom_range(3)), 4'(i)));
        run(100, 100, 300, used);
        checks++;
        if (used != 102 || got_res.size() != 100) begin
            failures++;
            $display("FAIL stream_rate got cycles=%0d results=%0d exp cycles=102 results=100",
                     used, got_res.size());
        end
    endtask

    task automatic test_backpressure();
        int used;
        logic [5:0] a;
        clear_got();
        for (int i = 0; i < 10000; i++) begin
            case ($urandom_range(7))
                0: a = 6'd0;
                1: a = 6'd63;
                default: a = 6'($urandom_range(63));
            endcase
            stim.push_back(mk({$urandom, $urandom} >> $urandom_range(63), a,
                              2'($urandom_range(3)), 4'(i)));
        end
        run(50, 50, 80000, used);
        checks++;
        if (got_res.size() != 10000) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=10000", got_res.size());
        end
    endtask

    task automatic test_full_release();
        stim_t s [3];
        for (int i = 0; i < 3; i++)
            s[i] = mk({$urandom, $urandom}, 6'($urandom_range(63)),
                      2'($urandom_range(3)), 4'(8 + i));
        bus.out_ready = 1'b0;
        drive(s[0]);
        @(posedge clk); #1;
        drive(s[1]);
        @(posedge clk); #1;
        drive(s[2]);
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
            bus.out_result !== ref_shift(s[0].d, s[0].a, s[0].t)) begin
            failures++;
            $display("FAIL full_hold got ir=%b ov=%b res=%h exp ir=0 ov=1 res=%h",
                     bus.in_ready, bus.out_valid, bus.out_result,
                     ref_shift(s[0].d, s[0].a, s[0].t));
        end
        bus.out_ready = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_ready got=%b exp=1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== (i == 1 ? 1'b0 : 1'b1) ||
                bus.out_result !== ref_shift(s[i].d, s[i].a, s[i].t) ||
                bus.out_tag !== s[i].tag) begin
                failures++;
                $display("FAIL release_order_%0d got ov=%b ir=%b res=%h tag=%h exp res=%h tag=%h",
                         i, bus.out_valid, bus.in_ready, bus.out_result, bus.out_tag,
                         ref_shift(s[i].d, s[i].a, s[i].t), s[i].tag);
            end
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL release_drain got ov=%b busy=%b exp=0/0", bus.out_valid, bus.busy);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_types();
        test_edges();
        test_stream();
        test_full_release();
        test_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
